bit_serializer_p2s: RTL and testbench

Parallel-to-serial front end for the bit-stream sequence detectors (e.g. the Moore 1010 detector). It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on a single serial line. That line drives the detector's serial input directly. A one-word holding register lets consecutive words stream with no idle bit between them, so detector patterns that span word boundaries are preserved.

---
 rtl/bit_serializer_p2s.sv | 87 ++++++++
 tb/tb_bit_serializer_p2s.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer_p2s.sv
// Parallel-to-serial front end for the serial sequence detectors.
// A one-word holding register lets consecutive words stream with no idle bit between them.
module bit_serializer_p2s #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             word_start,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_shifted;
    logic [CW-1:0]    cnt;
    logic             active;
    logic [WIDTH-1:0] hold;
    logic             hold_full;

    logic take;
    logic last;
    logic free;
    logic bypass;

    always_comb begin
        take   = data_valid & !hold_full;
        last   = active & (cnt == LAST_IDX);
        free   = !active | last;
        // A word goes straight into the shifter only when nothing is waiting ahead of it.
        bypass = free & !hold_full & take;
        if (MSB_FIRST) begin
            sr_shifted = {sr[WIDTH-2:0], 1'b0};
        end else begin
            sr_shifted = {1'b0, sr[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr        <= '0;
            cnt       <= '0;
            active    <= 1'b0;
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            if (free) begin
                if (hold_full) begin
                    sr     <= hold;
                    cnt    <= '0;
                    active <= 1'b1;
                end else if (take) begin
                    sr     <= data_in;
                    cnt    <= '0;
                    active <= 1'b1;
                end else begin
                    active <= 1'b0;
                end
            end else begin
                sr  <= sr_shifted;
                cnt <= cnt + CW'(1);
            end

            hold_full <= (hold_full & !(free & hold_full)) | (take & !(free & !hold_full));
            if (take && !bypass) begin
                hold <= data_in;
            end
        end
    end

    always_comb begin
        ser_bit    = active ? (MSB_FIRST ? sr[WIDTH-1] : sr[0]) : IDLE_BIT;
        ser_valid  = active;
        word_start = active & (cnt == '0);
        data_ready = !hold_full;
        busy       = active | hold_full;
    end

endmodule

// File: tb/tb_bit_serializer_p2s.sv
// Directed bench for bit_serializer_p2s: an MSB-first instance and an LSB-first instance.
module tb_bit_serializer_p2s;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready, ser_bit, ser_valid, word_start, busy;
    logic [7:0] data_in_l;
    logic       data_valid_l;
    logic       data_ready_l, ser_bit_l, ser_valid_l, word_start_l, busy_l;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bit_serializer_p2s #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .ser_bit(ser_bit), .ser_valid(ser_valid),
        .word_start(word_start), .busy(busy)
    );

    bit_serializer_p2s #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .data_in(data_in_l), .data_valid(data_valid_l),
        .data_ready(data_ready_l), .ser_bit(ser_bit_l), .ser_valid(ser_valid_l),
        .word_start(word_start_l), .busy(busy_l)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " ser_bit"}, ser_bit, 1'b0);
        chk({tag, " ser_valid"}, ser_valid, 1'b0);
        chk({tag, " word_start"}, word_start, 1'b0);
        chk({tag, " data_ready"}, data_ready, 1'b1);
        chk({tag, " busy"}, busy, 1'b0);
    endtask

    initial begin
        logic [7:0]  exp8;
        logic [15:0] exp16;
        logic [23:0] exp24;
        logic [3:0]  det_sh;
        int          det_cnt;

        reset = 1'b1;
        data_in = '0;
        data_valid = 1'b0;
        data_in_l = '0;
        data_valid_l = 1'b0;
        tick();
        tick();
        chk_idle("reset");
        reset = 1'b0;

        // 1: idle
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_idle($sformatf("idle%0d", i));
        end

        // 2: single word A0, MSB first
        exp8 = 8'b1010_0000;
        data_in = 8'hA0;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("single bit%0d", i), ser_bit, exp8[7-i]);
            chk($sformatf("single valid%0d", i), ser_valid, 1'b1);
            chk($sformatf("single start%0d", i), word_start, i == 0);
            tick();
        end
        chk("single after valid", ser_valid, 1'b0);
        chk("single after bit", ser_bit, 1'b0);
        chk("single after busy", busy, 1'b0);

        // 3: back-to-back AA, 55 with detector on the stream
        tick();
        exp16 = 16'b1010_1010_0101_0101;
        det_sh = '0;
        det_cnt = 0;
        data_in = 8'hAA;
        data_valid = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("b2b bit%0d", i), ser_bit, exp16[15-i]);
            chk($sformatf("b2b valid%0d", i), ser_valid, 1'b1);
            chk($sformatf("b2b start%0d", i), word_start, (i == 0) || (i == 8));
            if (i == 0) chk("b2b ready0", data_ready, 1'b1);
            if (i == 1) chk("b2b ready1", data_ready, 1'b0);
            det_sh = {det_sh[2:0], ser_bit};
            if (det_sh == 4'b1010) det_cnt++;
            if (i == 0) data_in = 8'h55;
            if (i == 1) data_valid = 1'b0;
            tick();
        end
        chk("b2b end valid", ser_valid, 1'b0);
        chk_int("b2b detections", det_cnt, 5);

        // 4: backpressure with three words C3, 5A, E7
        tick();
        exp24 = {8'b1100_0011, 8'b0101_1010, 8'b1110_0111};
        data_in = 8'hC3;
        data_valid = 1'b1;
        tick();
        for (int c = 0; c < 24; c++) begin
            chk($sformatf("bp bit%0d", c), ser_bit, exp24[23-c]);
            chk($sformatf("bp valid%0d", c), ser_valid, 1'b1);
            chk($sformatf("bp start%0d", c), word_start, (c % 8) == 0);
            chk($sformatf("bp ready%0d", c), data_ready, (c == 0) || (c >= 8 && c != 9 && c < 16) ? ((c == 0) || (c == 8)) : (c >= 16));
            chk($sformatf("bp busy%0d", c), busy, 1'b1);
            if (c == 0) data_in = 8'h5A;
            if (c == 1) data_in = 8'hE7;
            if (c == 9) data_valid = 1'b0;
            tick();
        end
        chk("bp end valid", ser_valid, 1'b0);
        chk("bp end busy", busy, 1'b0);

        // 5: reset mid-word with the hold register full
        tick();
        data_in = 8'h33;
        data_valid = 1'b1;
        tick();
        data_in = 8'hCC;
        tick();
        data_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("rst pre hold_full", data_ready, 1'b0);
        chk("rst pre start", word_start, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle("rst mid");
        tick();
        chk_idle("rst after");
        exp8 = 8'b1111_0000;
        data_in = 8'hF0;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("f0 bit%0d", i), ser_bit, exp8[7-i]);
            chk($sformatf("f0 valid%0d", i), ser_valid, 1'b1);
            chk($sformatf("f0 start%0d", i), word_start, i == 0);
            tick();
        end
        chk("f0 after valid", ser_valid, 1'b0);

        // 6: LSB-first instance, word 0D
        exp8 = 8'b1011_0000;
        chk("lsb idle valid", ser_valid_l, 1'b0);
        data_in_l = 8'h0D;
        data_valid_l = 1'b1;
        tick();
        data_valid_l = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("lsb bit%0d", i), ser_bit_l, exp8[7-i]);
            chk($sformatf("lsb valid%0d", i), ser_valid_l, 1'b1);
            chk($sformatf("lsb start%0d", i), word_start_l, i == 0);
            tick();
        end
        chk("lsb after valid", ser_valid_l, 1'b0);
        chk("lsb after bit", ser_bit_l, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
